// File: rtl/dm_sba_axil_bridge_pkg.sv
// Shared types for the debug-module system-bus-access AXI4-Lite bridge.
package dm_sba_axil_bridge_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic [2:0] {
      SBA_IDLE  = 3'd0,
      SBA_WRITE = 3'd1,
      SBA_BWAIT = 3'd2,
      SBA_READ  = 3'd3,
      SBA_RWAIT = 3'd4,
      SBA_DONE  = 3'd5
   } sba_axil_state_e;

endpackage

// File: rtl/dm_sba_axil_bridge.sv
// Turns the DM system-bus master req/gnt/r_valid protocol into single-beat AXI4-Lite
// transactions, one outstanding at a time; every access ends with one r_valid_o pulse.
module dm_sba_axil_bridge
   import dm_sba_axil_bridge_pkg::*;
#(
   parameter int unsigned BusWidth     = 32,
   parameter int unsigned AxiAddrWidth = 64,
   parameter logic [2:0]  AxiProt      = 3'b010
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_i,
   input  logic [BusWidth-1:0]     add_i,
   input  logic                    we_i,
   input  logic [BusWidth-1:0]     wdata_i,
   input  logic [BusWidth/8-1:0]   be_i,
   output logic                    gnt_o,
   output logic                    r_valid_o,
   output logic [BusWidth-1:0]     r_rdata_o,
   output logic                    err_o,
   output logic                    aw_valid_o,
   input  logic                    aw_ready_i,
   output logic [AxiAddrWidth-1:0] aw_addr_o,
   output logic [2:0]              aw_prot_o,
   output logic                    w_valid_o,
   input  logic                    w_ready_i,
   output logic [BusWidth-1:0]     w_data_o,
   output logic [BusWidth/8-1:0]   w_strb_o,
   input  logic                    b_valid_i,
   output logic                    b_ready_o,
   input  logic [1:0]              b_resp_i,
   output logic                    ar_valid_o,
   input  logic                    ar_ready_i,
   output logic [AxiAddrWidth-1:0] ar_addr_o,
   output logic [2:0]              ar_prot_o,
   input  logic                    r_valid_i,
   output logic                    r_ready_o,
   input  logic [BusWidth-1:0]     r_data_i,
   input  logic [1:0]              r_resp_i
);

   // Zero-extends or truncates, depending on which side is wider.
   function automatic logic [AxiAddrWidth-1:0] to_axi_addr(input logic [BusWidth-1:0] a);
      return AxiAddrWidth'(a);
   endfunction

   sba_axil_state_e       state_q, state_d;
   logic [BusWidth-1:0]   addr_q, addr_d;
   logic [BusWidth-1:0]   wdata_q, wdata_d;
   logic [BusWidth/8-1:0] be_q, be_d;
   logic [BusWidth-1:0]   rdata_q, rdata_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic                  err_q, err_d;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      rdata_d   = rdata_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      err_d     = err_q;
      unique case (state_q)
         SBA_IDLE: begin
            if (req_i) begin
               addr_d    = add_i;
               wdata_d   = wdata_i;
               be_d      = be_i;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               err_d     = 1'b0;
               state_d   = we_i ? SBA_WRITE : SBA_READ;
            end
         end
         SBA_WRITE: begin
            // A channel already done keeps valid low, so ready alone marks its handshake.
            aw_done_d = aw_done_q | aw_ready_i;
            w_done_d  = w_done_q | w_ready_i;
            if (aw_done_d && w_done_d) state_d = SBA_BWAIT;
         end
         SBA_BWAIT: begin
            if (b_valid_i) begin
               err_d   = (axi_resp_e'(b_resp_i) != RESP_OKAY);
               state_d = SBA_DONE;
            end
         end
         SBA_READ: begin
            if (ar_ready_i) state_d = SBA_RWAIT;
         end
         SBA_RWAIT: begin
            if (r_valid_i) begin
               err_d   = (axi_resp_e'(r_resp_i) != RESP_OKAY);
               rdata_d = err_d ? '0 : r_data_i;
               state_d = SBA_DONE;
            end
         end
         SBA_DONE: state_d = SBA_IDLE;
         default:  state_d = SBA_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= SBA_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         rdata_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         rdata_q   <= rdata_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         err_q     <= err_d;
      end
   end

   assign gnt_o      = (state_q == SBA_IDLE) && req_i;
   assign r_valid_o  = (state_q == SBA_DONE);
   assign err_o      = (state_q == SBA_DONE) && err_q;
   assign r_rdata_o  = rdata_q;

   assign aw_valid_o = (state_q == SBA_WRITE) && !aw_done_q;
   assign aw_addr_o  = to_axi_addr(addr_q);
   assign aw_prot_o  = AxiProt;
   assign w_valid_o  = (state_q == SBA_WRITE) && !w_done_q;
   assign w_data_o   = wdata_q;
   assign w_strb_o   = be_q;
   assign b_ready_o  = (state_q == SBA_BWAIT);

   assign ar_valid_o = (state_q == SBA_READ);
   assign ar_addr_o  = to_axi_addr(addr_q);
   assign ar_prot_o  = AxiProt;
   assign r_ready_o  = (state_q == SBA_RWAIT);

endmodule

// File: tb/tb_dm_sba_axil_bridge.sv
// Directed bench for dm_sba_axil_bridge: read/write vector tables plus hand-built sequences.
module tb_dm_sba_axil_bridge;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i, we_i;
   logic [31:0] add_i, wdata_i;
   logic [3:0]  be_i;
   logic        gnt_o, r_valid_o, err_o;
   logic [31:0] r_rdata_o;
   logic        aw_valid_o, aw_ready_i, w_valid_o, w_ready_i;
   logic [63:0] aw_addr_o, ar_addr_o;
   logic [2:0]  aw_prot_o, ar_prot_o;
   logic [31:0] w_data_o;
   logic [3:0]  w_strb_o;
   logic        b_valid_i, b_ready_o;
   logic [1:0]  b_resp_i, r_resp_i;
   logic        ar_valid_o, ar_ready_i, r_valid_i, r_ready_o;
   logic [31:0] r_data_i;

   always #5 clk_i = ~clk_i;

   dm_sba_axil_bridge dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .we_i(we_i),
      .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
      .r_rdata_o(r_rdata_o), .err_o(err_o),
      .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_prot_o(aw_prot_o),
      .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
      .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
      .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_prot_o(ar_prot_o),
      .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  resp;
      int          ar_wait;
      logic [63:0] exp_addr;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } rd_vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          aw_wait;
      int          w_wait;
      logic [1:0]  bresp;
      logic [63:0] exp_addr;
      logic        exp_err;
   } wr_vec_t;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_rdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_read(input rd_vec_t v);
      req_i = 1'b1; we_i = 1'b0; add_i = v.addr; wdata_i = '0; be_i = '0;
      #1 chk("rd_gnt", gnt_o, 1);
      step();
      req_i = 1'b0; add_i = '0;
      for (int k = 0; k <= v.ar_wait; k++) begin
         ar_ready_i = (k == v.ar_wait);
         #1;
         chk("rd_ar_valid", ar_valid_o, 1);
         chk("rd_ar_addr", ar_addr_o, v.exp_addr);
         chk("rd_r_ready_early", r_ready_o, 0);
         step();
      end
      ar_ready_i = 1'b0;
      chk("rd_ar_valid_drop", ar_valid_o, 0);
      chk("rd_r_ready", r_ready_o, 1);
      r_valid_i = 1'b1; r_data_i = v.data; r_resp_i = v.resp;
      step();
      r_valid_i = 1'b0; r_data_i = '0; r_resp_i = '0;
      chk("rd_r_valid_o", r_valid_o, 1);
      chk("rd_rdata", r_rdata_o, v.exp_rdata);
      chk("rd_err", err_o, v.exp_err);
      last_rdata = v.exp_rdata;
      step();
      chk("rd_pulse_end", r_valid_o, 0);
   endtask

   task automatic do_write(input wr_vec_t v);
      bit aw_d, w_d;
      aw_d = 0; w_d = 0;
      req_i = 1'b1; we_i = 1'b1; add_i = v.addr; wdata_i = v.wdata; be_i = v.be;
      #1 chk("wr_gnt", gnt_o, 1);
      step();
      req_i = 1'b0; we_i = 1'b0; add_i = '0; wdata_i = '0; be_i = '0;
      for (int k = 0; k < 20 && !(aw_d && w_d); k++) begin
         aw_ready_i = (k >= v.aw_wait);
         w_ready_i  = (k >= v.w_wait);
         #1;
         chk("wr_aw_valid", aw_valid_o, !aw_d);
         chk("wr_w_valid", w_valid_o, !w_d);
         chk("wr_b_ready_early", b_ready_o, 0);
         if (!aw_d) begin
            chk("wr_aw_addr", aw_addr_o, v.exp_addr);
            chk("wr_aw_prot", aw_prot_o, 3'b010);
         end
         if (!w_d) begin
            chk("wr_w_data", w_data_o, v.wdata);
            chk("wr_w_strb", w_strb_o, v.be);
         end
         if (aw_ready_i) aw_d = 1;
         if (w_ready_i) w_d = 1;
         step();
      end
      aw_ready_i = 1'b0; w_ready_i = 1'b0;
      chk("wr_handshakes_done", aw_d && w_d, 1);
      chk("wr_b_ready", b_ready_o, 1);
      chk("wr_aw_valid_off", aw_valid_o, 0);
      chk("wr_w_valid_off", w_valid_o, 0);
      chk("wr_no_early_pulse", r_valid_o, 0);
      b_valid_i = 1'b1; b_resp_i = v.bresp;
      step();
      b_valid_i = 1'b0; b_resp_i = '0;
      chk("wr_r_valid_o", r_valid_o, 1);
      chk("wr_err", err_o, v.exp_err);
      chk("wr_rdata_kept", r_rdata_o, last_rdata);
      chk("wr_b_ready_off", b_ready_o, 0);
      step();
      chk("wr_pulse_end", r_valid_o, 0);
   endtask

   rd_vec_t rd_tab[5];
   wr_vec_t wr_tab[4];

   initial begin
      logic [7:0] exp_gnt, exp_rv, exp_ar;

      rd_tab[0] = '{32'h8000_0000, 32'h1234_5678, 2'b00, 0, 64'h0000_0000_8000_0000, 32'h1234_5678, 1'b0};
      rd_tab[1] = '{32'h0000_1004, 32'hDEAD_BEEF, 2'b11, 1, 64'h0000_0000_0000_1004, 32'h0000_0000, 1'b1};
      rd_tab[2] = '{32'hFFFF_FFFC, 32'hA5A5_0F0F, 2'b00, 2, 64'h0000_0000_FFFF_FFFC, 32'hA5A5_0F0F, 1'b0};
      rd_tab[3] = '{32'h0000_0010, 32'h1111_2222, 2'b10, 0, 64'h0000_0000_0000_0010, 32'h0000_0000, 1'b1};
      rd_tab[4] = '{32'h2000_0000, 32'h5555_AAAA, 2'b01, 0, 64'h0000_0000_2000_0000, 32'h0000_0000, 1'b1};

      wr_tab[0] = '{32'h4000_0000, 32'hCAFE_F00D, 4'b0011, 3, 0, 2'b00, 64'h0000_0000_4000_0000, 1'b0};
      wr_tab[1] = '{32'h4000_0008, 32'h0BAD_F00D, 4'b1111, 0, 0, 2'b00, 64'h0000_0000_4000_0008, 1'b0};
      wr_tab[2] = '{32'h9000_0004, 32'h0000_00FF, 4'b0001, 0, 2, 2'b10, 64'h0000_0000_9000_0004, 1'b1};
      wr_tab[3] = '{32'hF000_0000, 32'h8765_4321, 4'b1100, 1, 1, 2'b11, 64'h0000_0000_F000_0000, 1'b1};

      rst_i = 1'b1;
      req_i = 0; we_i = 0; add_i = '0; wdata_i = '0; be_i = '0;
      aw_ready_i = 0; w_ready_i = 0; b_valid_i = 0; b_resp_i = '0;
      ar_ready_i = 0; r_valid_i = 0; r_data_i = '0; r_resp_i = '0;
      last_rdata = '0;
      #12;
      chk("rst_gnt", gnt_o, 0);
      chk("rst_r_valid", r_valid_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_rdata", r_rdata_o, 0);
      chk("rst_valids", {aw_valid_o, w_valid_o, ar_valid_o}, 0);
      chk("rst_readies", {b_ready_o, r_ready_o}, 0);
      chk("rst_addr", ar_addr_o, 0);
      @(negedge clk_i) rst_i = 1'b0;
      step();

      // read and write tables, interleaved so writes see a known r_rdata_o
      do_read(rd_tab[0]);
      do_write(wr_tab[0]);
      for (int i = 1; i < 5; i++) do_read(rd_tab[i]);
      for (int i = 1; i < 4; i++) do_write(wr_tab[i]);

      // stray B and R beats while idle must not be accepted
      b_valid_i = 1'b1; r_valid_i = 1'b1; b_resp_i = 2'b10; r_data_i = 32'hFFFF_FFFF;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("idle_b_ready", b_ready_o, 0);
         chk("idle_r_ready", r_ready_o, 0);
         chk("idle_r_valid_o", r_valid_o, 0);
         step();
      end
      b_valid_i = 1'b0; r_valid_i = 1'b0; b_resp_i = '0; r_data_i = '0;
      chk("idle_rdata_kept", r_rdata_o, last_rdata);

      // req held across two zero-wait reads
      exp_gnt = 8'b0001_0001; exp_ar = 8'b0010_0010; exp_rv = 8'b1000_1000;
      req_i = 1'b1; we_i = 1'b0; add_i = 32'h0000_0100;
      ar_ready_i = 1'b1; r_valid_i = 1'b1; r_data_i = 32'h7777_0001; r_resp_i = 2'b00;
      for (int c = 0; c < 8; c++) begin
         if (c == 5) req_i = 1'b0;
         #1;
         chk("hold_gnt", gnt_o, exp_gnt[c]);
         chk("hold_ar_valid", ar_valid_o, exp_ar[c]);
         chk("hold_r_valid_o", r_valid_o, exp_rv[c]);
         if (exp_rv[c]) chk("hold_rdata", r_rdata_o, 32'h7777_0001);
         step();
      end
      ar_ready_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0; add_i = '0;
      last_rdata = 32'h7777_0001;

      // async reset while waiting for B
      req_i = 1'b1; we_i = 1'b1; add_i = 32'h1000_0000; wdata_i = 32'h1357_9BDF; be_i = 4'hF;
      aw_ready_i = 1'b1; w_ready_i = 1'b1;
      step();
      req_i = 1'b0; we_i = 1'b0;
      step();
      aw_ready_i = 1'b0; w_ready_i = 1'b0;
      chk("bw_b_ready", b_ready_o, 1);
      rst_i = 1'b1;
      #1;
      chk("midrst_b_ready", b_ready_o, 0);
      chk("midrst_r_valid", r_valid_o, 0);
      chk("midrst_rdata", r_rdata_o, 0);
      chk("midrst_aw_addr", aw_addr_o, 0);
      chk("midrst_w_strb", w_strb_o, 0);
      @(negedge clk_i) rst_i = 1'b0;
      step();
      last_rdata = '0;
      do_read(rd_tab[2]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
